// File: rtl/shiftadd_mult_ctrl.sv
// Shift-and-add multiplier sequencer: load, then per-bit check/add/shift.
// Optional SHIFTADD_MULT_EARLY_EXIT_EN: finish as soon as the multiplier is zero.
module shiftadd_mult_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     inputdata_ready,
  input  logic                     mult_lsb,
  input  logic                     mult_zero,
  output logic                     loaddata,
  output logic                     add_en,
  output logic                     shift_en,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(WIDTH)-1:0] iter
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    ADD,
    SHIFT,
    DONE
  } state_t;

  state_t state;

`ifndef SHIFTADD_MULT_EARLY_EXIT_EN
  logic unused_mult_zero;
  assign unused_mult_zero = mult_zero;
`endif

  // Outputs are registered with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      iter     <= '0;
      loaddata <= 1'b0;
      add_en   <= 1'b0;
      shift_en <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      loaddata <= 1'b0;
      add_en   <= 1'b0;
      shift_en <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (inputdata_ready) begin
            state    <= LOAD;
            iter     <= '0;
            loaddata <= 1'b1;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          state <= CHECK;
          busy  <= 1'b1;
        end
        CHECK: begin
`ifdef SHIFTADD_MULT_EARLY_EXIT_EN
          if (mult_zero) begin
            state <= DONE;
            done  <= 1'b1;
          end else
`endif
          if (mult_lsb) begin
            state  <= ADD;
            add_en <= 1'b1;
            busy   <= 1'b1;
          end else begin
            state    <= SHIFT;
            shift_en <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ADD: begin
          state    <= SHIFT;
          shift_en <= 1'b1;
          busy     <= 1'b1;
        end
        SHIFT: begin
          if (iter == LAST) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= CHECK;
            iter  <= iter + IW'(1);
            busy  <= 1'b1;
          end
        end
        DONE: begin
          if (inputdata_ready) begin
            done <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          iter  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shiftadd_mult_ctrl.sv
// Bench for shiftadd_mult_ctrl with a behavioural datapath and
// a scoreboard of expected per-operation results.
module tb_shiftadd_mult_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic inputdata_ready = 1'b1;
  logic mult_lsb, mult_zero;
  logic loaddata, add_en, shift_en, busy, done;
  logic [2:0] iter;

  logic [7:0] a_op = '0;
  logic [7:0] b_op = '0;
  logic [7:0] mq = '0;
  logic [7:0] lo = '0;
  logic [8:0] acc = '0;

  int vectors = 0;
  int errs = 0;
  int cyc = 0;

  typedef struct {
    int lat;
    int adds;
    int shifts;
    int dlen;
    int it;
    logic [15:0] prod;
    logic [7:0] mask;
    bit gap;
  } exp_t;

  exp_t sb[$];

  shiftadd_mult_ctrl #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .inputdata_ready(inputdata_ready),
    .mult_lsb(mult_lsb),
    .mult_zero(mult_zero),
    .loaddata(loaddata),
    .add_en(add_en),
    .shift_en(shift_en),
    .busy(busy),
    .done(done),
    .iter(iter)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural datapath driven by the strobes
  assign mult_lsb  = mq[0];
  assign mult_zero = (mq == 8'h00);

  always @(posedge clk) begin
    if (loaddata) begin
      acc <= '0;
      lo  <= '0;
      mq  <= b_op;
    end else if (add_en) begin
      acc <= {1'b0, acc[7:0]} + {1'b0, a_op};
    end else if (shift_en) begin
      {acc, lo} <= {acc, lo} >> 1;
      mq <= mq >> 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input int dlen, input bit gap);
    exp_t e;
    e.lat = 1;
    e.adds = 0;
    e.shifts = 0;
    for (int i = 0; i < W; i++) begin
`ifdef SHIFTADD_MULT_EARLY_EXIT_EN
      if ((b >> i) == 8'h00) begin
        e.lat += 1;
        break;
      end
`endif
      e.lat += 2 + int'(b[i]);
      e.adds += int'(b[i]);
      e.shifts++;
    end
    e.it = (e.shifts == W) ? W - 1 : e.shifts;
    e.mask = b;
    e.prod = 16'(a) * 16'(b);
    e.dlen = dlen;
    e.gap = gap;
    return e;
  endfunction

  // Monitor
  initial begin
    int start, dstart, fall_cyc, nadd, nshift, nload, lat_obs, it_obs;
    logic [7:0] amask;
    logic [15:0] prod_obs;
    bit prev_done;
    exp_t e;
    start = 0; dstart = 0; fall_cyc = 0; nadd = 0; nshift = 0;
    nload = 0; lat_obs = 0; it_obs = 0; amask = '0; prod_obs = '0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_done = 1'b0;
        nload = 0;
      end else begin
        check("strobe_excl",
              32'(int'(loaddata) + int'(add_en) + int'(shift_en) > 1), 0);
        if (loaddata) begin
          check("busy_load", busy, 1);
          if (sb.size() > 0 && sb[0].gap)
            check("b2b_gap", cyc - fall_cyc, 1);
          start = cyc; nadd = 0; nshift = 0; amask = '0;
          nload++;
        end
        if (add_en) begin
          nadd++;
          amask[iter] = 1'b1;
        end
        if (shift_en) nshift++;
        if (done && !prev_done) begin
          dstart = cyc;
          lat_obs = cyc - start;
          it_obs = int'(iter);
          prod_obs = {acc[7:0], lo};
          check("busy_done", busy, 0);
        end
        if (!done && prev_done) begin
          fall_cyc = cyc;
          if (sb.size() == 0) begin
            check("sb_underflow", 1, 0);
          end else begin
            e = sb.pop_front();
            check("latency", lat_obs, e.lat);
            check("adds", nadd, e.adds);
            check("shifts", nshift, e.shifts);
            check("add_iters", amask, e.mask);
            check("done_len", cyc - dstart, e.dlen);
            check("loads", nload, 1);
            check("done_iter", it_obs, e.it);
`ifndef SHIFTADD_MULT_EARLY_EXIT_EN
            check("product", prod_obs, e.prod);
`endif
          end
          nload = 0;
        end
        prev_done = done;
      end
    end
  end

  task automatic run(input logic [7:0] a, input logic [7:0] b,
                     input int hold, input int drop_it, input bit gap);
    int n;
    @(negedge clk);
    a_op = a;
    b_op = b;
    inputdata_ready = 1'b1;
    sb.push_back(model(a, b, (drop_it >= 0) ? 1 : hold + 1, gap));
    n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      if (drop_it >= 0 && busy && int'(iter) == drop_it)
        inputdata_ready = 1'b0;
      n++;
    end
    if (!done) check("done_timeout", 0, 1);
    repeat (hold) @(negedge clk);
    inputdata_ready = 1'b0;
  endtask

  initial begin
    int n;
    // Reset held with a pending request
    repeat (2) begin
      @(negedge clk);
      check("rst_out", {loaddata, add_en, shift_en, busy, done}, 0);
      check("rst_iter", iter, 0);
    end
    reset = 1'b0;
    inputdata_ready = 1'b0;

    run(8'd3, 8'd5, 2, -1, 1'b0);
    run(8'h07, 8'hFF, 0, -1, 1'b1);
    run(8'h09, 8'h00, 1, -1, 1'b1);
    run(8'hC3, 8'h5A, 0, 3, 1'b1);

    // Reset in ADD at iteration 4
    @(negedge clk);
    a_op = 8'h11;
    b_op = 8'hFF;
    inputdata_ready = 1'b1;
    n = 0;
    while (!(add_en && iter == 3'd4) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_reach", 32'(add_en && iter == 3'd4), 1);
    reset = 1'b1;
    inputdata_ready = 1'b0;
    @(negedge clk);
    check("rst_mid_out", {loaddata, add_en, shift_en, busy, done}, 0);
    check("rst_mid_iter", iter, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run(8'd200, 8'd13, 0, -1, 1'b0);
    for (int i = 0; i < 4; i++)
      run(8'($urandom), 8'($urandom), int'($urandom_range(0, 2)), -1, 1'b1);

    repeat (4) @(negedge clk);
    check("idle_end", {busy, done}, 0);
    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/shiftadd_mult_ctrl.md
# shiftadd_mult_ctrl

Sequencing controller for the shift-and-add multiplier datapath. It accepts an operand-ready request, loads the operand registers, and steps the datapath through one add/shift iteration per multiplier bit. It reports completion with a four-phase done handshake. It sits between the input-capture logic (which raises `inputdata_ready`) and the multiplier datapath (which receives `loaddata`, `add_en`, `shift_en`).

## Interface
- `WIDTH`, default 8: operand width in bits. Equals the number of iterations. Legal range is 2 to 32.
- `clk`  input  1  system clock. All state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `inputdata_ready`  input  1  request level from input capture. High means both operands are valid.
- `mult_lsb`  input  1  current LSB of the datapath multiplier register.
- `mult_zero`  input  1  datapath multiplier register is all zeros. Used only under the configuration macro.
- `loaddata`  output  1  load the operands into the datapath and clear the accumulator.
- `add_en`  output  1  add the multiplicand into the accumulator this cycle.
- `shift_en`  output  1  shift the accumulator/multiplier pair right by one this cycle.
- `busy`  output  1  an operation is in progress (states LOAD, CHECK, ADD, SHIFT).
- `done`  output  1  product is valid. Held until the handshake completes.
- `iter`  output  $clog2(WIDTH)  index of the current iteration, 0 to WIDTH-1.

## Operation
- Moore FSM with states IDLE, LOAD, CHECK, ADD, SHIFT, DONE. All outputs decode from the registered state and the counter only.
- **IDLE:** all strobes low. Moves to LOAD when `inputdata_ready`=1; otherwise stays in IDLE.
- **LOAD:** `loaddata`=1 for exactly one cycle and `iter` is cleared to 0. Moves to CHECK.
- **CHECK:** no strobes. Moves to ADD if `mult_lsb`=1, else to SHIFT.
- **ADD:** `add_en`=1 for one cycle. Moves to SHIFT.
- **SHIFT:** `shift_en`=1 for one cycle.
  - If `iter`=WIDTH-1, moves to DONE.
  - Otherwise increments `iter` and moves to CHECK.
- **DONE:** `done`=1 and `iter` holds WIDTH-1.
  - Stays in DONE while `inputdata_ready`=1.
  - Moves to IDLE on the first sampled `inputdata_ready`=0 (four-phase handshake).
- `inputdata_ready` is ignored in LOAD, CHECK, ADD and SHIFT. Deasserting it mid-operation does not abort. DONE is still reached, then exits to IDLE on the next edge.
- Undefined state encodings return to IDLE.
- `iter` never wraps. The counter increments only in SHIFT with `iter`<WIDTH-1.
- `add_en`, `shift_en` and `loaddata` are mutually exclusive in every cycle.

## Timing
- **Reset:** on an edge with `reset`=1, state becomes IDLE and `iter` becomes 0. From the following cycle, every output is 0.
- **Reset priority:** reset overrides every transition, including mid-iteration and in DONE.
- **Start:** edge E0 samples `inputdata_ready`=1 in IDLE. `loaddata` is high in the cycle after E0, and CHECK follows at E1.
- **Per bit:** 2 cycles when `mult_lsb`=0, 3 cycles when `mult_lsb`=1.
- **Latency:** `done` first rises after E0 + 1 + Σ(2 + b_i) edges, where b_i is multiplier bit i.
  - WIDTH=8, multiplier 0x00: 17 edges.
  - WIDTH=8, multiplier 0xFF: 25 edges.
- **Back-to-back:** the minimum gap from `done` falling to the next `loaddata` is 1 cycle (IDLE, then LOAD).

## Configuration
- Macro: `SHIFTADD_MULT_EARLY_EXIT_EN`.
- **Defined:** in CHECK, `mult_zero`=1 moves directly to DONE, skipping the remaining iterations.
  - `iter` freezes at its current value.
  - Multiplier 0x00 gives `done` at E0+2.
- **Undefined:** `mult_zero` is ignored. Iteration count and latency are always the fixed figures in Timing.
- The port list is identical in both builds.

## Test plan
- **Reset:** assert `reset` for 2 cycles with `inputdata_ready`=1 -> all outputs 0, state IDLE, no `loaddata` until reset is released.
- **Fixed latency, 3×5:** WIDTH=8, multiplicand 3, multiplier 5, `inputdata_ready` held high -> one `loaddata` pulse, `add_en` at iterations 0 and 2, 8 `shift_en` pulses, `done` 19 edges after E0, datapath product 15. `done` holds until ready drops, then IDLE next edge.
- **All-ones/zero extremes:** multiplier 0xFF -> 8 `add_en`, `done` at E0+25. Multiplier 0x00 without the macro -> 0 `add_en`, `done` at E0+17. Multiplier 0x00 with `SHIFTADD_MULT_EARLY_EXIT_EN` -> `done` at E0+2, no `shift_en`.
- **Ready dropped mid-operation:** deassert `inputdata_ready` at iteration 3 -> operation completes, `done` pulses exactly 1 cycle, then IDLE.
- **Reset mid-operation:** assert `reset` in ADD at iteration 4 -> next cycle all outputs 0 and `iter`=0. A fresh request then restarts from LOAD.
- **Back-to-back:** two requests separated by one low cycle of `inputdata_ready` -> second `loaddata` exactly 1 cycle after `done` falls. Strobes are never simultaneous throughout.
